// File: rtl/uop_fetch_wide.sv
// Wide uop fetch stage: reads FETCH_WIDTH-slot bundles from the uop buffer and
// registers them toward decode, with redirect, empty detection and a hardware loop.
module uop_fetch_wide #(
  parameter int unsigned UOP_BUF_SIZE = 64,
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned INSTR_W      = 64,
  parameter int unsigned LOOP_CNT_W   = 8,
  localparam int unsigned AW = $clog2(UOP_BUF_SIZE),
  localparam int unsigned BW = FETCH_WIDTH * INSTR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  redirect,
  input  logic [AW-1:0]         redirect_addr,
  input  logic                  enabled,
  input  logic                  next_enabled,
  input  logic                  prev_valid,
  output logic                  stalled,
  input  logic                  next_stalled,
  output logic                  valid,
  output logic [AW-1:0]         uop_addr,
  input  logic [AW-1:0]         uop_tail,
  input  logic [BW-1:0]         uop_data,
  input  logic [FETCH_WIDTH-1:0] uop_mask,
  output logic [BW-1:0]         instr_out,
  output logic [FETCH_WIDTH-1:0] slot_valid,
  input  logic                  loop_en,
  input  logic                  loop_start_req,
  input  logic [AW-1:0]         loop_begin,
  input  logic [AW-1:0]         loop_end,
  input  logic [LOOP_CNT_W-1:0] loop_count,
  output logic                  loop_active,
  output logic [31:0]           fetch_count
);

  logic                  empty_c;
  logic                  fire_c;
  logic                  jump_c;
  logic [AW-1:0]         next_addr_c;
  logic [AW-1:0]         loop_begin_q;
  logic [AW-1:0]         loop_end_q;
  logic [LOOP_CNT_W-1:0] loop_cnt_q;

  // Fetch decision and next read address; power-of-two size makes +1 wrap naturally.
  always_comb begin
    empty_c     = (uop_addr == uop_tail);
    fire_c      = enabled && prev_valid && !empty_c && (!valid || !next_stalled);
    jump_c      = loop_active && (uop_addr == loop_end_q);
    next_addr_c = jump_c ? loop_begin_q : AW'(uop_addr + AW'(1));
  end

  assign stalled = prev_valid && next_stalled && valid;

  // Output register, read pointer, loop state and perf counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uop_addr     <= '0;
      valid        <= 1'b0;
      slot_valid   <= '0;
      instr_out    <= '0;
      loop_active  <= 1'b0;
      loop_begin_q <= '0;
      loop_end_q   <= '0;
      loop_cnt_q   <= '0;
      fetch_count  <= '0;
    end else if (redirect) begin
      uop_addr    <= redirect_addr;
      valid       <= 1'b0;
      slot_valid  <= '0;
      loop_active <= 1'b0;
    end else if (clear) begin
      uop_addr    <= '0;
      valid       <= 1'b0;
      slot_valid  <= '0;
      loop_active <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (fire_c) begin
        instr_out   <= uop_data;
        slot_valid  <= uop_mask;
        valid       <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
        uop_addr    <= next_addr_c;
        if (jump_c) begin
          loop_cnt_q <= LOOP_CNT_W'(loop_cnt_q - LOOP_CNT_W'(1));
          if (loop_cnt_q == LOOP_CNT_W'(1)) loop_active <= 1'b0;
        end
      end else if (next_enabled && !next_stalled) begin
        valid      <= 1'b0;
        slot_valid <= '0;
      end
      // A new arm overrides any counter update from a same-cycle backward jump.
      if (loop_start_req) begin
        loop_begin_q <= loop_begin;
        loop_end_q   <= loop_end;
        loop_cnt_q   <= loop_count;
        loop_active  <= loop_en && (loop_count != '0);
      end
    end
  end

endmodule
